neuron_ctrl: RTL and testbench
==============================

# neuron_ctrl

Frame sequencer for a single leaky integrate-and-fire `neuron`. It buffers 8-bit input spike frames in a small FIFO and applies each frame to the neuron's `inputs` for a programmed number of timesteps. During that window it gates `learn` and counts output spikes, then returns the count through a valid/ready result port. Between frames it clears the neuron's accumulator. It sits between the host-facing I/O logic and one `neuron` instance.

## Interface
- `FIFO_DEPTH`, 4: frame buffer entries; power of two, ≥2.
- `STEPS_W`, 4: width of the timestep count.
- `CNT_W`, 8: width of the spike counter.

- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `frame_in` in 8: input spike frame, bit i drives neuron input i.
- `frame_valid` in 1: `frame_in` is valid.
- `frame_ready` out 1: FIFO not full.
- `train` in 1: this frame trains; sampled with `frame_in` and stored per entry.
- `cfg_steps` in STEPS_W: timesteps per frame; sampled at frame start; 0 is treated as 1.
- `spikes_out` out 8: to neuron `inputs`.
- `learn_out` out 1: to neuron `learn`.
- `neuron_clr` out 1: one-cycle clear pulse to the neuron accumulator.
- `spike_in` in 1: neuron `spike_out`.
- `result_count` out CNT_W: spikes counted for the completed frame.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.

## Operation
- FIFO entries are {train, frame[7:0]}.
- Push occurs when `frame_valid && frame_ready`. `frame_ready` = !full, so no push is accepted at full. A simultaneous push and pop is legal when the FIFO is not full. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, RUN, REPORT, CLEAR.
  - IDLE: when the FIFO is non-empty, the next edge pops the head into the frame register. The same edge latches `train`, loads the step counter with max(`cfg_steps`,1), zeroes the spike counter and moves to RUN. With the FIFO empty, the FSM stays in IDLE.
  - RUN: `spikes_out` = frame register and `learn_out` = latched train. On each edge, if `spike_in`=1 the spike counter increments, saturating at 2^CNT_W−1. The step counter decrements on each edge; on the edge where it equals 1 the FSM moves to REPORT.
  - REPORT: `spikes_out`=0, `learn_out`=0, `result_valid`=1, `result_count` held stable. On an edge with `result_ready`=1 the FSM moves to CLEAR. It stalls indefinitely otherwise, and the FIFO keeps accepting pushes while it does.
  - CLEAR: `neuron_clr`=1 for exactly one cycle, then IDLE.
- `spike_in` is counted only in RUN cycles. It is ignored in all other states.
- All outputs are registered or decoded from the state register only. No combinational path runs from `spike_in` or `result_ready` to any output.
- Reset values: state=IDLE, FIFO empty, `frame_ready`=1, `spikes_out`=0, `learn_out`=0, `neuron_clr`=0, `result_valid`=0, `result_count`=0.
- Reset asserted mid-frame aborts the frame. Any buffered frames are discarded and no result is produced.

## Timing
- Push at edge E0 into an empty FIFO with the FSM in IDLE:
  - E1 pops the frame; RUN spans cycles E1..E1+N.
  - `result_valid` rises at E1+N.
- Minimum frame period is N+3 cycles: IDLE, N×RUN, one REPORT cycle with `result_ready`=1, and CLEAR.
- With the FIFO kept non-empty, the next IDLE→RUN transition occurs one cycle after CLEAR. The one-cycle IDLE is mandatory.
- `cfg_steps` changes only take effect at the next IDLE→RUN transition.

## Structure
- Package `neuron_ctrl_pkg`: FSM state enum (IDLE, RUN, REPORT, CLEAR), the FIFO entry width constant (9), and default parameter constants.
- One sub-module, `spike_fifo`: a synchronous FIFO with full/empty flags and async reset, parameterised on depth and width.
- FSM, step counter and spike counter live in `neuron_ctrl`.

## Test plan
- Single frame: push 0xA5, `train`=0, `cfg_steps`=3, `spike_in` high in RUN cycles 1 and 3 → `spikes_out`=0xA5 for exactly 3 cycles, `learn_out`=0, `result_count`=2, `neuron_clr` pulses once after the handshake.
- Full FIFO: push 5 frames back-to-back with the FSM stalled in REPORT (`result_ready`=0) → the 5th push is refused (`frame_ready`=0). Releasing `result_ready` gives results in push order.
- Saturation: `CNT_W`=2, `cfg_steps`=7, `spike_in` held high → `result_count`=3.
- `cfg_steps`=0 → exactly 1 RUN cycle. Push with `train`=1 → `learn_out`=1 only during RUN.
- Reset mid-RUN with 2 frames queued → next cycle all outputs are at reset values, `frame_ready`=1, and no `result_valid` ever appears for those frames.
- Simultaneous push and pop at FIFO occupancy 1 → occupancy stays 1 and the pushed frame is processed next.

Source files
------------

// File: rtl/neuron_ctrl_pkg.sv
// Shared types and constants for the neuron frame sequencer.
// The FIFO entry packs {train, frame[7:0]}.
package neuron_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam int ENTRY_W        = 9;
    localparam int FRAME_W        = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_STEPS_W    = 4;
    localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO with full/empty flags and asynchronous reset.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module spike_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/neuron_ctrl.sv
// Frame sequencer for one leaky integrate-and-fire neuron: buffers frames, drives
// each for cfg_steps timesteps, counts output spikes and reports the count.
module neuron_ctrl
    import neuron_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int STEPS_W    = DEF_STEPS_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic               train,
    input  logic [STEPS_W-1:0] cfg_steps,
    output logic [7:0]         spikes_out,
    output logic               learn_out,
    output logic               neuron_clr,
    input  logic               spike_in,
    output logic [CNT_W-1:0]   result_count,
    output logic               result_valid,
    input  logic               result_ready,
    output state_t             fsm_state
);

    // Handshakes (frame and result ports): a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds valid and data until then.

    state_t               state;
    state_t               next_state;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [FRAME_W-1:0]   frame_reg;
    logic                 train_reg;
    logic [STEPS_W-1:0]   step_cnt;
    logic [CNT_W-1:0]     spike_cnt;

    spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (frame_valid && frame_ready),
        .pop   (pop),
        .din   ({train, frame_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign frame_ready = !fifo_full;
    assign pop         = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = RUN;
            RUN:     if (step_cnt == STEPS_W'(1)) next_state = REPORT;
            REPORT:  if (result_ready) next_state = CLEAR;
            CLEAR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A programmed step count of zero runs a single timestep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_reg <= '0;
            train_reg <= 1'b0;
            step_cnt  <= '0;
            spike_cnt <= '0;
        end else if (pop) begin
            frame_reg <= fifo_dout[FRAME_W-1:0];
            train_reg <= fifo_dout[ENTRY_W-1];
            step_cnt  <= (cfg_steps == '0) ? STEPS_W'(1) : cfg_steps;
            spike_cnt <= '0;
        end else if (state == RUN) begin
            step_cnt <= step_cnt - STEPS_W'(1);
            if (spike_in && (spike_cnt != '1)) spike_cnt <= spike_cnt + CNT_W'(1);
        end
    end

    assign spikes_out   = (state == RUN) ? frame_reg : '0;
    assign learn_out    = (state == RUN) && train_reg;
    assign result_valid = (state == REPORT);
    assign result_count = spike_cnt;
    assign neuron_clr   = (state == CLEAR);
    assign fsm_state    = state;

endmodule

// File: tb/tb_neuron_ctrl.sv
// Bench for neuron_ctrl: a directed vector table, hand-written corner sequences and a
// randomized run checked against a timestamp-level reference model.
module tb_neuron_ctrl;
    import neuron_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int T     = 800;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] frame_in;
    logic       frame_valid;
    logic       train;
    logic [3:0] cfg_steps;
    logic       spike_in;
    logic       result_ready;

    logic       frame_ready, learn_out, neuron_clr, result_valid;
    logic [7:0] spikes_out, result_count;
    state_t     fsm_state;

    logic       s_ready, s_learn, s_clr, s_valid;
    logic [7:0] s_spikes;
    logic [1:0] s_count;
    state_t     s_state;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [1:0] exp2_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    neuron_ctrl dut (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .train(train), .cfg_steps(cfg_steps),
        .spikes_out(spikes_out), .learn_out(learn_out), .neuron_clr(neuron_clr),
        .spike_in(spike_in), .result_count(result_count), .result_valid(result_valid),
        .result_ready(result_ready), .fsm_state(fsm_state)
    );

    neuron_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(s_ready), .train(train), .cfg_steps(cfg_steps),
        .spikes_out(s_spikes), .learn_out(s_learn), .neuron_clr(s_clr),
        .spike_in(spike_in), .result_count(s_count), .result_valid(s_valid),
        .result_ready(result_ready), .fsm_state(s_state)
    );

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [7:0] fin, input logic tr,
                         input logic [3:0] st, input logic sp, input logic rr);
        frame_valid  = fv;
        frame_in     = fin;
        train        = tr;
        cfg_steps    = st;
        spike_in     = sp;
        result_ready = rr;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_frame_ready"}, frame_ready, 1);
        check({tag, "_spikes_out"}, spikes_out, 0);
        check({tag, "_learn_out"}, learn_out, 0);
        check({tag, "_neuron_clr"}, neuron_clr, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_result_count"}, result_count, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 8'h00, 0, 4'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    logic [7:0] seen_q[$];
    int n_val, n_run, n_lrn, n_lrn_run;
    logic [7:0] last_cnt;
    logic [1:0] last_cnt2;

    // Observes n cycles with inputs held, logging each frame that enters RUN.
    task automatic collect(input int n);
        logic [7:0] prev;
        prev = 8'h00;
        seen_q.delete();
        n_val = 0; n_run = 0; n_lrn = 0; n_lrn_run = 0;
        last_cnt = 8'h00; last_cnt2 = 2'd0;
        repeat (n) begin
            if (spikes_out != 8'h00 && spikes_out != prev) seen_q.push_back(spikes_out);
            prev = spikes_out;
            if (spikes_out != 8'h00) n_run++;
            if (learn_out) n_lrn++;
            if (learn_out && spikes_out != 8'h00) n_lrn_run++;
            if (result_valid) begin
                n_val++;
                last_cnt  = result_count;
                last_cnt2 = s_count;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       fv;
        logic [7:0] fin;
        logic       tr;
        logic [3:0] st;
        logic       sp;
        logic       rr;
        logic [7:0] e_spk;
        logic       e_lrn;
        logic       e_clr;
        logic       e_val;
        logic [7:0] e_cnt;
        logic       e_rdy;
    } vec_t;

    function automatic vec_t row(input logic fv, input logic [7:0] fin, input logic sp,
                                 input logic rr, input logic [7:0] e_spk, input logic e_clr,
                                 input logic e_val, input logic [7:0] e_cnt);
        vec_t v;
        v.fv = fv; v.fin = fin; v.tr = 1'b0; v.st = 4'd3; v.sp = sp; v.rr = rr;
        v.e_spk = e_spk; v.e_lrn = 1'b0; v.e_clr = e_clr; v.e_val = e_val;
        v.e_cnt = e_cnt; v.e_rdy = 1'b1;
        return v;
    endfunction

    // ---------------- random stimulus and reference model ----------------
    logic       pv[T];
    logic [7:0] pf[T];
    logic       pt[T];
    logic [3:0] ps[T];
    logic       sp_a[T];
    logic       rr_a[T];
    logic [7:0] e_spk[T];
    logic       e_lrn[T];
    logic       e_val[T];
    logic       e_clr[T];
    logic       e_rdy[T];
    logic [7:0] e_cnt[T];

    // Frame k starts on the first edge where the queue is non-empty and at least two
    // edges have passed since the previous frame's result handshake; it then runs for
    // max(steps,1) edges and reports until the first edge with result_ready high.
    task automatic build_model();
        logic [8:0] mq[$];
        int next_free;
        next_free = 0;
        exp_q.delete();
        exp2_q.delete();
        for (int c = 0; c < T; c++) begin
            e_spk[c] = 0; e_lrn[c] = 0; e_val[c] = 0; e_clr[c] = 0; e_cnt[c] = 0;
        end
        for (int t = 0; t < T; t++) begin
            int  occ;
            occ = mq.size();
            if (occ > 0 && t >= next_free) begin
                logic [8:0] ent;
                int n, cnt, h;
                ent = mq.pop_front();
                n   = (ps[t] == 0) ? 1 : int'(ps[t]);
                cnt = 0;
                for (int e = t + 1; e <= t + n; e++)
                    if (e < T && sp_a[e]) cnt++;
                if (cnt > 255) cnt = 255;
                h = t + n + 1;
                while (h < T && !rr_a[h]) h++;
                for (int c = t; c < t + n && c < T; c++) begin
                    e_spk[c] = ent[7:0];
                    e_lrn[c] = ent[8];
                end
                for (int c = t + n; c < h && c < T; c++) begin
                    e_val[c] = 1'b1;
                    e_cnt[c] = 8'(cnt);
                end
                if (h < T) begin
                    e_clr[h] = 1'b1;
                    exp_q.push_back(8'(cnt));
                    exp2_q.push_back((cnt > 3) ? 2'd3 : 2'(cnt));
                end
                next_free = h + 2;
            end
            if (pv[t] && occ < DEPTH) mq.push_back({pt[t], pf[t]});
            e_rdy[t] = (mq.size() < DEPTH);
        end
    endtask

    task automatic check_cycle(input int c);
        check("rnd_frame_ready", frame_ready, e_rdy[c]);
        check("rnd_spikes_out", spikes_out, e_spk[c]);
        check("rnd_learn_out", learn_out, e_lrn[c]);
        check("rnd_neuron_clr", neuron_clr, e_clr[c]);
        check("rnd_result_valid", result_valid, e_val[c]);
        check("rnd_sat_result_valid", s_valid, e_val[c]);
        if (e_val[c]) check("rnd_result_count", result_count, e_cnt[c]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t tbl[9];
        logic [7:0] want[4];

        reset = 1'b1;
        drive(0, 8'h00, 0, 4'd0, 0, 0);

        // Single frame 0xA5, 3 steps, spikes in RUN cycles 1 and 3.
        tbl[0] = row(1, 8'hA5, 0, 0, 8'h00, 0, 0, 8'd0);
        tbl[1] = row(0, 8'h00, 0, 0, 8'hA5, 0, 0, 8'd0);
        tbl[2] = row(0, 8'h00, 1, 0, 8'hA5, 0, 0, 8'd0);
        tbl[3] = row(0, 8'h00, 0, 0, 8'hA5, 0, 0, 8'd0);
        tbl[4] = row(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'd2);
        tbl[5] = row(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'd2);
        tbl[6] = row(0, 8'h00, 0, 1, 8'h00, 1, 0, 8'd0);
        tbl[7] = row(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'd0);
        tbl[8] = row(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'd0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].fv, tbl[i].fin, tbl[i].tr, tbl[i].st, tbl[i].sp, tbl[i].rr);
            @(negedge clk);
            check($sformatf("tbl%0d_spikes_out", i), spikes_out, tbl[i].e_spk);
            check($sformatf("tbl%0d_learn_out", i), learn_out, tbl[i].e_lrn);
            check($sformatf("tbl%0d_neuron_clr", i), neuron_clr, tbl[i].e_clr);
            check($sformatf("tbl%0d_result_valid", i), result_valid, tbl[i].e_val);
            check($sformatf("tbl%0d_frame_ready", i), frame_ready, tbl[i].e_rdy);
            if (tbl[i].e_val) check($sformatf("tbl%0d_result_count", i), result_count, tbl[i].e_cnt);
        end

        // Full FIFO while stalled in REPORT; results come back in push order.
        do_reset();
        drive(1, 8'h11, 0, 4'd1, 0, 0); @(negedge clk);
        drive(0, 8'h00, 0, 4'd1, 0, 0); @(negedge clk);
        check("full_run_first", spikes_out, 8'h11);
        @(negedge clk);
        check("full_in_report", result_valid, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h20 + 8'(i), 1'(i), 4'd1, 0, 0);
            check($sformatf("full_push%0d_ready", i), frame_ready, (i < 4) ? 1 : 0);
            @(negedge clk);
        end
        drive(0, 8'h00, 0, 4'd1, 0, 1);
        collect(60);
        check("full_result_total", n_val, 5);
        check("full_frames_run", seen_q.size(), 4);
        for (int i = 0; i < 4; i++) want[i] = 8'h20 + 8'(i);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check($sformatf("full_order%0d", i), seen_q[i], want[i]);

        // cfg_steps = 0 runs once; train=1 raises learn_out only while running.
        do_reset();
        drive(1, 8'h3C, 1, 4'd0, 1, 1); @(negedge clk);
        drive(0, 8'h00, 0, 4'd0, 1, 1);
        collect(20);
        check("steps0_run_cycles", n_run, 1);
        check("steps0_learn_cycles", n_lrn, 1);
        check("steps0_learn_in_run", n_lrn_run, 1);
        check("steps0_results", n_val, 1);
        check("steps0_count", last_cnt, 1);

        // Saturation: 7 steps with spike_in held high.
        do_reset();
        drive(1, 8'h81, 0, 4'd7, 1, 1); @(negedge clk);
        drive(0, 8'h00, 0, 4'd7, 1, 1);
        collect(20);
        check("sat_run_cycles", n_run, 7);
        check("sat_results", n_val, 1);
        check("sat_count_w8", last_cnt, 7);
        check("sat_count_w2", last_cnt2, 3);

        // Reset mid-RUN with two frames queued.
        do_reset();
        drive(1, 8'h55, 0, 4'd5, 1, 0); @(negedge clk);
        drive(1, 8'h66, 0, 4'd5, 1, 0); @(negedge clk);
        drive(1, 8'h77, 0, 4'd5, 1, 0); @(negedge clk);
        drive(0, 8'h00, 0, 4'd5, 1, 1);
        check("rst_mid_running", spikes_out, 8'h55);
        #2 reset = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid");
        reset = 1'b0;
        collect(40);
        check("rst_mid_no_result", n_val, 0);
        check("rst_mid_no_run", n_run, 0);
        check("rst_mid_ready_after", frame_ready, 1);

        // Simultaneous push and pop at occupancy 1.
        do_reset();
        drive(1, 8'h0F, 0, 4'd1, 0, 0); @(negedge clk);
        drive(0, 8'h00, 0, 4'd1, 0, 0); @(negedge clk);
        drive(1, 8'h33, 0, 4'd1, 0, 0); @(negedge clk);
        check("pp_report_a", result_valid, 1);
        drive(0, 8'h00, 0, 4'd1, 0, 1); @(negedge clk);
        check("pp_clear_pulse", neuron_clr, 1);
        drive(0, 8'h00, 0, 4'd1, 0, 0); @(negedge clk);
        check("pp_idle_state", fsm_state, IDLE);
        drive(1, 8'h44, 0, 4'd1, 0, 0); @(negedge clk);
        check("pp_pop_b", spikes_out, 8'h33);
        check("pp_run_state", fsm_state, RUN);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'hD0 + 8'(i), 0, 4'd1, 0, 0);
            check($sformatf("pp_fill%0d_ready", i), frame_ready, 1);
            @(negedge clk);
        end
        drive(0, 8'h00, 0, 4'd1, 0, 0);
        check("pp_full_after_fill", frame_ready, 0);
        drive(0, 8'h00, 0, 4'd1, 0, 1);
        collect(60);
        check("pp_results", n_val, 5);
        check("pp_frames_run", seen_q.size(), 4);
        want[0] = 8'h44; want[1] = 8'hD0; want[2] = 8'hD1; want[3] = 8'hD2;
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check($sformatf("pp_order%0d", i), seen_q[i], want[i]);

        // Randomized run against the reference model.
        for (int t = 0; t < T; t++) begin
            pv[t]   = (t < 450) && ($urandom_range(0, 2) == 0);
            pf[t]   = 8'($urandom_range(0, 255));
            pt[t]   = 1'($urandom_range(0, 1));
            ps[t]   = 4'($urandom_range(0, 5));
            sp_a[t] = 1'($urandom_range(0, 1));
            rr_a[t] = (t >= 550) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        build_model();
        do_reset();
        for (int t = 0; t < T; t++) begin
            if (t > 0) check_cycle(t - 1);
            drive(pv[t], pf[t], pt[t], ps[t], sp_a[t], rr_a[t]);
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 1, 0);
                end else begin
                    check("rnd_sb_count", result_count, exp_q.pop_front());
                end
            end
            if (s_valid && result_ready) begin
                if (exp2_q.size() == 0) begin
                    check("rnd_sat_unexpected_result", 1, 0);
                end else begin
                    check("rnd_sat_sb_count", s_count, exp2_q.pop_front());
                end
            end
            @(negedge clk);
        end
        check_cycle(T - 1);
        check("rnd_results_left", exp_q.size(), 0);
        check("rnd_sat_results_left", exp2_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
